vga_screen_mux: RTL and testbench

VGA_SCREEN_MUX -- requirements
Module: vga_screen_mux

---
 rtl/vga_screen_mux.sv | 178 +++++++++++++++++
 tb/tb_vga_screen_mux.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_screen_mux.sv
// ---------------------------------------------------------------------------
// vga_screen_mux
//
// Chooses one of N_SCREENS pixel sources and drives it to a VGA output
// stage. All sources share one timing generator, so only the colour is
// multiplexed. Screen changes take effect only at the start of vertical
// sync, which means a visible frame never mixes two sources. Optionally,
// GAP_FRAMES black frames are inserted between the old and the new screen.
//
// Parameters
//   N_SCREENS     number of sources (2..16)
//   COLOR_W       bits per colour channel
//   GAP_FRAMES    black frames inserted on each change (0 = direct switch)
//   VS_ACTIVE_LOW polarity of vs_in, VGA_HS and VGA_VS (1 = active low)
//
// Ports
//   clock          system clock; all logic runs on its rising edge
//   reset          synchronous, active-high reset
//   screen_req     per-screen enables; bit 0 has the highest priority
//   src_rgb        packed {R,G,B} per source, source i at [i*3*COLOR_W +: 3*COLOR_W]
//   hs_in, vs_in   shared sync inputs
//   blank_n_in     shared active-video flag (1 = visible pixel)
//   VGA_R/G/B      registered output colour
//   VGA_HS/VS      sync outputs, delayed one cycle to line up with the colour
//   VGA_BLANK_N    active-video flag, delayed one cycle
//   active_screen  index of the screen being shown; N_SCREENS (NONE) while black
//   switch_done    one-cycle pulse when a new active_screen value commits
// ---------------------------------------------------------------------------
module vga_screen_mux #(
   parameter int N_SCREENS     = 6,
   parameter int COLOR_W       = 8,
   parameter int GAP_FRAMES    = 1,
   parameter bit VS_ACTIVE_LOW = 1'b1,
   localparam int SEL_W        = $clog2(N_SCREENS + 1)
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [N_SCREENS-1:0]           screen_req,
   input  logic [N_SCREENS*3*COLOR_W-1:0] src_rgb,
   input  logic                           hs_in,
   input  logic                           vs_in,
   input  logic                           blank_n_in,
   output logic [COLOR_W-1:0]             VGA_R,
   output logic [COLOR_W-1:0]             VGA_G,
   output logic [COLOR_W-1:0]             VGA_B,
   output logic                           VGA_HS,
   output logic                           VGA_VS,
   output logic                           VGA_BLANK_N,
   output logic [SEL_W-1:0]               active_screen,
   output logic                           switch_done
);

   localparam int                GAP_W     = 4;
   localparam logic [SEL_W-1:0]  NONE      = SEL_W'(N_SCREENS);
   // Level of a sync line when it is not asserted.
   localparam logic              SYNC_IDLE = VS_ACTIVE_LOW;

   typedef enum logic [1:0] {
      SHOW,
      WAIT_VS,
      GAP
   } state_t;

   state_t                  state;
   logic [GAP_W-1:0]        gap_cnt;
   logic                    vs_d;
   logic                    vs_start;
   logic [SEL_W-1:0]        target;
   logic [3*COLOR_W-1:0]    pix;

   // -------------------------------------------------------------------------
   // Priority encoder: lowest set request wins, NONE when nothing is requested.
   // Scanning from the top down lets the lowest index overwrite the others.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   // -------------------------------------------------------------------------
   always_comb begin
      target = NONE;
      for (int i = N_SCREENS - 1; i >= 0; i--) begin
         if (screen_req[i]) target = SEL_W'(i);
      end
   end

   // First cycle vs_in sits at its asserted level while the previous cycle did not.
   assign vs_start = (vs_in != SYNC_IDLE) && (vs_d == SYNC_IDLE);

   // -------------------------------------------------------------------------
   // Source select. Only indices below N_SCREENS are compared, so NONE (or any
   // other out-of-range code) selects nothing and yields black.
   // -------------------------------------------------------------------------
   always_comb begin
      pix = '0;
      for (int i = 0; i < N_SCREENS; i++) begin
         if (active_screen == SEL_W'(i)) pix = src_rgb[i*3*COLOR_W +: 3*COLOR_W];
      end
   end

   // -------------------------------------------------------------------------
   // Switch controller. A request seen in SHOW only arms WAIT_VS; the commit
   // always happens on a later vs_start, so a change never lands mid-frame.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge value of every other register.
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= SHOW;
         active_screen <= NONE;
         gap_cnt       <= '0;
         switch_done   <= 1'b0;
      end else begin
         switch_done <= 1'b0;
         case (state)
            SHOW: begin
               if (target != active_screen) state <= WAIT_VS;
            end

            WAIT_VS: begin
               if (vs_start) begin
                  if (target == active_screen) begin
                     // Request withdrawn before the frame boundary.
                     state <= SHOW;
                  end else if (GAP_FRAMES == 0) begin
                     active_screen <= target;
                     switch_done   <= 1'b1;
                     state         <= SHOW;
                  end else begin
                     active_screen <= NONE;
                     gap_cnt       <= GAP_W'(GAP_FRAMES);
                     state         <= GAP;
                  end
               end
            end

            GAP: begin
               if (vs_start) begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
                  // Last black frame ends: commit whatever is requested now,
                  // even NONE, so the gap length never depends on the request.
                  if (gap_cnt == GAP_W'(1)) begin
                     active_screen <= target;
                     switch_done   <= 1'b1;
                     state         <= SHOW;
                  end
               end
            end

            default: state <= SHOW;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Output pipeline: one register stage for colour and timing alike, so the
   // sync outputs stay aligned with the pixels they frame. Colour uses the
   // active_screen value held before this edge, so a commit shows on the next pixel.
   // -------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         vs_d        <= SYNC_IDLE;
         VGA_HS      <= SYNC_IDLE;
         VGA_VS      <= SYNC_IDLE;
         VGA_BLANK_N <= 1'b0;
         VGA_R       <= '0;
         VGA_G       <= '0;
         VGA_B       <= '0;
      end else begin
         vs_d        <= vs_in;
         VGA_HS      <= hs_in;
         VGA_VS      <= vs_in;
         VGA_BLANK_N <= blank_n_in;
         if (blank_n_in && (state != GAP)) begin
            {VGA_R, VGA_G, VGA_B} <= pix;
         end else begin
            {VGA_R, VGA_G, VGA_B} <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_screen_mux.sv
// ---------------------------------------------------------------------------
// tb_vga_screen_mux
//
// Three copies of the mux (GAP_FRAMES = 0, 1 and 3) share one stimulus
// stream. A frame generator drives the sync/blank inputs, colours are
// randomised every cycle, and a per-copy reference model expressed as
// "pending request / black frames still to show" predicts every output
// on every cycle. Directed steps walk through the interesting switching
// scenarios, then a randomised phase changes requests and pulses reset.
// ---------------------------------------------------------------------------
module tb_vga_screen_mux;

   localparam int NS    = 6;
   localparam int CW    = 8;
   localparam int FRAME = 40;
   localparam int NONE  = NS;

   logic          clock      = 1'b0;
   logic          reset      = 1'b1;
   logic [NS-1:0] screen_req = '0;
   logic [143:0]  src_rgb    = '0;
   logic          hs_in      = 1'b1;
   logic          vs_in      = 1'b1;
   logic          blank_n_in = 1'b0;

   logic [CW-1:0] vr[3];
   logic [CW-1:0] vg[3];
   logic [CW-1:0] vb[3];
   logic          vhs[3];
   logic          vvs[3];
   logic          vbn[3];
   logic [2:0]    act[3];
   logic          done[3];

   int n_vec = 0;
   int n_err = 0;
   int pos   = 5;

   // Reference model state, one entry per copy.
   int m_active[3];
   bit m_pending[3];
   int m_gap_left[3];
   int pulses[3];
   bit m_vs_prev = 1'b1;

   always #5 clock = ~clock;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      vga_screen_mux #(
         .N_SCREENS    (NS),
         .COLOR_W      (CW),
         .GAP_FRAMES   ((k == 2) ? 3 : k),
         .VS_ACTIVE_LOW(1'b1)
      ) u_dut (
         .clock        (clock),
         .reset        (reset),
         .screen_req   (screen_req),
         .src_rgb      (src_rgb),
         .hs_in        (hs_in),
         .vs_in        (vs_in),
         .blank_n_in   (blank_n_in),
         .VGA_R        (vr[k]),
         .VGA_G        (vg[k]),
         .VGA_B        (vb[k]),
         .VGA_HS       (vhs[k]),
         .VGA_VS       (vvs[k]),
         .VGA_BLANK_N  (vbn[k]),
         .active_screen(act[k]),
         .switch_done  (done[k])
      );
   end

   function automatic int gap_of(int k);
      return (k == 2) ? 3 : k;
   endfunction

   function automatic int lowest(logic [NS-1:0] r);
      for (int i = 0; i < NS; i++) if (r[i]) return i;
      return NONE;
   endfunction

   task automatic check(input string tag, input int k, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s [gap=%0d]: observed %0h expected %0h", tag, gap_of(k), obs, exp);
      end
   endtask

   // One clock: capture the applied inputs, let the edge happen, advance the
   // model with those inputs and compare every output of every copy.
   task automatic tick();
      logic [NS-1:0] c_req;
      logic [143:0]  c_rgb;
      logic          c_hs, c_vs, c_bn, c_rst;
      int            tgt;
      bit            vs_start;
      logic [23:0]   e_rgb;
      logic          e_done;
      c_req = screen_req;
      c_rgb = src_rgb;
      c_hs  = hs_in;
      c_vs  = vs_in;
      c_bn  = blank_n_in;
      c_rst = reset;
      @(posedge clock);
      #1;
      tgt      = lowest(c_req);
      vs_start = (c_vs == 1'b0) && m_vs_prev;
      for (int k = 0; k < 3; k++) begin
         e_rgb  = '0;
         e_done = 1'b0;
         if (c_rst) begin
            m_active[k]   = NONE;
            m_pending[k]  = 1'b0;
            m_gap_left[k] = 0;
         end else begin
            // Pixel uses the screen shown before this edge.
            if (c_bn && m_active[k] != NONE) e_rgb = c_rgb[m_active[k]*24 +: 24];
            if (m_gap_left[k] > 0) begin
               if (vs_start) begin
                  if (m_gap_left[k] == 1) begin
                     m_active[k] = tgt;
                     e_done      = 1'b1;
                  end
                  m_gap_left[k]--;
               end
            end else if (m_pending[k]) begin
               if (vs_start) begin
                  m_pending[k] = 1'b0;
                  if (tgt != m_active[k]) begin
                     if (gap_of(k) == 0) begin
                        m_active[k] = tgt;
                        e_done      = 1'b1;
                     end else begin
                        m_active[k]   = NONE;
                        m_gap_left[k] = gap_of(k);
                     end
                  end
               end
            end else if (tgt != m_active[k]) begin
               m_pending[k] = 1'b1;
            end
         end
         check("rgb", k, {8'h0, vr[k], vg[k], vb[k]}, {8'h0, e_rgb});
         check("sync", k, {29'h0, vhs[k], vvs[k], vbn[k]},
               c_rst ? 32'h6 : {29'h0, c_hs, c_vs, c_bn});
         check("active", k, {29'h0, act[k]}, 32'(m_active[k]));
         check("done", k, {31'h0, done[k]}, {31'h0, e_done});
         if (done[k] === 1'b1) pulses[k]++;
      end
      m_vs_prev = c_rst ? 1'b1 : c_vs;
   endtask

   // Frame generator: vs low for 3 cycles, hs low every 10, visible 5..37.
   task automatic run(input int n, input bit rnd);
      for (int i = 0; i < n; i++) begin
         vs_in      = (pos >= 3);
         hs_in      = (pos % 10 != 0);
         blank_n_in = (pos >= 5 && pos <= 37);
         for (int j = 0; j < 18; j++) src_rgb[j*8 +: 8] = 8'($urandom);
         if (rnd) begin
            if ($urandom_range(0, 59) == 0)
               screen_req = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
            reset = ($urandom_range(0, 2999) == 0);
         end
         tick();
         pos = (pos + 1) % FRAME;
      end
   endtask

   // Runs up to and including the next vs_start edge.
   task automatic run_past_vs();
      run((FRAME - pos) % FRAME + 1, 1'b0);
   endtask

   task automatic align(input int p);
      run((p - pos + FRAME) % FRAME, 1'b0);
   endtask

   initial begin
      int p;
      logic h_prev, v_prev;
      for (int k = 0; k < 3; k++) begin
         m_active[k]   = NONE;
         m_pending[k]  = 1'b0;
         m_gap_left[k] = 0;
         pulses[k]     = 0;
      end

      // Reset state, then a single request on source 0.
      run(3, 1'b0);
      reset      = 1'b0;
      screen_req = 6'b000001;
      run_past_vs();
      check("req0_gap1_first_vs_active", 1, {29'h0, act[1]}, NONE);
      check("req0_gap1_first_vs_pulses", 1, pulses[1], 0);
      check("req0_gap0_first_vs_active", 0, {29'h0, act[0]}, 0);
      run_past_vs();
      check("req0_gap1_second_vs_active", 1, {29'h0, act[1]}, 0);
      check("req0_gap1_pulses", 1, pulses[1], 1);

      // Two requests at once: the lower index wins.
      screen_req = 6'b000110;
      run(5 * FRAME, 1'b0);
      for (int k = 0; k < 3; k++) check("priority_active", k, {29'h0, act[k]}, 1);

      // Mid-frame move from 0 to 3 on the direct-switch copy.
      screen_req = 6'b000001;
      run(5 * FRAME, 1'b0);
      align(20);
      p          = pulses[0];
      screen_req = 6'b001000;
      run(FRAME - 20, 1'b0);
      check("midframe_hold_active", 0, {29'h0, act[0]}, 0);
      check("midframe_hold_pulses", 0, pulses[0], p);
      run(1, 1'b0);
      check("midframe_commit_active", 0, {29'h0, act[0]}, 3);
      check("midframe_commit_pulses", 0, pulses[0], p + 1);

      // Request bounces 0 -> 3 -> 0 inside one frame.
      screen_req = 6'b000001;
      run(5 * FRAME, 1'b0);
      align(10);
      p          = pulses[0];
      screen_req = 6'b001000;
      run(3, 1'b0);
      screen_req = 6'b000001;
      run(2 * FRAME, 1'b0);
      check("bounce_active", 0, {29'h0, act[0]}, 0);
      check("bounce_pulses", 0, pulses[0], p);
      check("bounce_active_gap3", 2, {29'h0, act[2]}, 0);

      // Blanked all-ones input gives black; syncs follow one cycle later.
      blank_n_in = 1'b0;
      src_rgb    = '1;
      for (int i = 0; i < 8; i++) begin
         hs_in  = 1'($urandom);
         vs_in  = 1'($urandom);
         h_prev = hs_in;
         v_prev = vs_in;
         tick();
         check("blank_black", 0, {8'h0, vr[0], vg[0], vb[0]}, 0);
         check("hs_delay", 0, {31'h0, vhs[0]}, {31'h0, h_prev});
         check("vs_delay", 0, {31'h0, vvs[0]}, {31'h0, v_prev});
      end

      // Reset in the middle of a 3-frame gap, then a fresh full gap.
      screen_req = 6'b000001;
      run(6 * FRAME, 1'b0);
      align(10);
      screen_req = 6'b000100;
      run_past_vs();
      check("gap3_entered", 2, {29'h0, act[2]}, NONE);
      run(5, 1'b0);
      reset = 1'b1;
      run(1, 1'b0);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check("midgap_reset_active", k, {29'h0, act[k]}, NONE);
         check("midgap_reset_rgb", k, {8'h0, vr[k], vg[k], vb[k]}, 0);
         check("midgap_reset_sync", k, {29'h0, vhs[k], vvs[k], vbn[k]}, 32'h6);
      end
      p = pulses[2];
      run_past_vs();
      run_past_vs();
      run_past_vs();
      check("fresh_gap_still_black", 2, {29'h0, act[2]}, NONE);
      check("fresh_gap_no_pulse", 2, pulses[2], p);
      run_past_vs();
      check("fresh_gap_commit", 2, {29'h0, act[2]}, 2);
      check("fresh_gap_pulse", 2, pulses[2], p + 1);

      // Randomised requests with occasional resets.
      run(200 * FRAME, 1'b1);
      reset = 1'b0;
      run(2, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
